// File: rtl/apu_pkg.sv
// Shared constants, state encoding and LFSR step for the multi-voice APU.
package apu_pkg;

  // Per-voice waveform selection.
  localparam logic [1:0] MODE_SQUARE = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_NOISE  = 2'd2;
  localparam logic [1:0] MODE_OFF    = 2'd3;

  // Envelope state of one voice.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DECAY = 2'd2
  } voice_state_t;

  localparam logic [3:0] VOL_MAX   = 4'd15;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // One step of the right-shifting 8-bit Galois LFSR.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    logic [7:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ LFSR_TAPS;
    return nxt;
  endfunction

endpackage

// File: rtl/apu_voice.sv
// One sound voice: hold/decay envelope FSM, phase oscillator, noise LFSR
// and the 4-bit sample it contributes to the mix.
module apu_voice
  import apu_pkg::*;
#(
  parameter int PERIOD_BITS = 16,
  parameter int LOG2_STEP   = 2,
  parameter int DUR_BITS    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   trig,
  input  logic [1:0]             mode,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic [DUR_BITS-1:0]    duration,
  output logic                   busy,
  output logic [3:0]             sample
);

  localparam logic [PERIOD_BITS-1:0] STEP = PERIOD_BITS'(1) << LOG2_STEP;

  voice_state_t            state, state_next;
  logic [DUR_BITS-1:0]     hold_cnt, hold_next;
  logic [3:0]              vol, vol_next;
  logic [1:0]              mode_q;
  logic [PERIOD_BITS-1:0]  period_q;
  logic [PERIOD_BITS-1:0]  phase;
  logic                    sq;
  logic [7:0]              lfsr;
  logic                    frozen;
  logic                    wrap;
  logic [7:0]              saw_prod;

  // A latched period shorter than one phase step cannot produce a tone.
  assign frozen   = period_q < STEP;
  assign wrap     = phase[PERIOD_BITS-1:LOG2_STEP] == '0;
  assign saw_prod = {4'b0, phase[PERIOD_BITS-1 -: 4]} * {4'b0, vol};
  assign busy     = state != ST_IDLE;

  // Envelope state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // updates from pre-edge values regardless of statement order.
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      vol      <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      vol      <= vol_next;
    end
  end

  // Envelope next-state: a trigger restarts the note and masks a same-cycle tick.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_next = state;
    hold_next  = hold_cnt;
    vol_next   = vol;
    if (trig) begin
      hold_next  = duration;
      vol_next   = VOL_MAX;
      state_next = (duration == '0) ? ST_DECAY : ST_HOLD;
    end else if (tick) begin
      case (state)
        ST_HOLD: begin
          hold_next = hold_cnt - 1'b1;
          if (hold_cnt <= DUR_BITS'(1)) state_next = ST_DECAY;
        end
        ST_DECAY: begin
          if (vol <= 4'd1) begin
            vol_next   = '0;
            state_next = ST_IDLE;
          end else begin
            vol_next = vol - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Oscillator: config latch on trigger, phase countdown with reload on wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= MODE_SQUARE;
      period_q <= '0;
      phase    <= '0;
      sq       <= 1'b0;
      lfsr     <= LFSR_SEED;
    end else if (trig) begin
      mode_q   <= mode;
      period_q <= period;
      phase    <= period;
    end else if (state != ST_IDLE && !frozen) begin
      if (wrap) begin
        phase <= phase + period_q - STEP;
        sq    <= ~sq;
        lfsr  <= lfsr_next(lfsr);
      end else begin
        phase <= phase - STEP;
      end
    end
  end

  // Sample selection from the current waveform and envelope volume.
  always_comb begin
    sample = '0;
    if (state != ST_IDLE && !frozen) begin
      case (mode_q)
        MODE_SQUARE: sample = sq ? vol : 4'd0;
        MODE_SAW:    sample = saw_prod[7:4];
        MODE_NOISE:  sample = lfsr[0] ? vol : 4'd0;
        default:     sample = '0;
      endcase
    end
  end

endmodule

// File: rtl/apu_multi_voice.sv
// Multi-voice sound-effect generator: N_CH voices summed and emitted as PWM.
module apu_multi_voice
  import apu_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int PERIOD_BITS = 16,
  parameter int LOG2_STEP   = 2,
  parameter int DUR_BITS    = 8,
  parameter int PWM_BITS    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic [N_CH-1:0]               trig,
  input  logic [2*N_CH-1:0]             mode,
  input  logic [PERIOD_BITS*N_CH-1:0]   period,
  input  logic [DUR_BITS*N_CH-1:0]      duration,
  output logic [N_CH-1:0]               busy,
  output logic                          sound
);

  localparam int MIX_W = 4 + $clog2(N_CH);

  logic [3:0]          sample [N_CH];
  logic [MIX_W-1:0]    mix;
  logic [PWM_BITS-1:0] mix_aligned;
  logic [PWM_BITS-1:0] pwm_cnt;

  for (genvar i = 0; i < N_CH; i++) begin : g_voice
    apu_voice #(
      .PERIOD_BITS (PERIOD_BITS),
      .LOG2_STEP   (LOG2_STEP),
      .DUR_BITS    (DUR_BITS)
    ) u_voice (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .trig     (trig[i]),
      .mode     (mode[2*i +: 2]),
      .period   (period[PERIOD_BITS*i +: PERIOD_BITS]),
      .duration (duration[DUR_BITS*i +: DUR_BITS]),
      .busy     (busy[i]),
      .sample   (sample[i])
    );
  end

  // Unsigned mix; MIX_W is wide enough that the sum can never overflow.
  always_comb begin
    mix = '0;
    for (int i = 0; i < N_CH; i++) mix = mix + MIX_W'(sample[i]);
  end

  // Left-align the mix so full scale spans the PWM timebase.
  assign mix_aligned = PWM_BITS'(mix) << (PWM_BITS - MIX_W);

  // Free-running PWM timebase and registered comparator output.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
      sound   <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      sound   <= mix_aligned > pwm_cnt;
    end
  end

endmodule
